// File: rtl/axi_smi_read_bridge.sv
// AXI4 read-channel slave: turns each AR burst into one SMI read request flit and
// streams the matching SMI response frame back as R beats, one transaction at a time.
module axi_smi_read_bridge #(
    parameter int unsigned DataIndexSize = 4,
    parameter int unsigned AxiIdWidth    = 4
) (
    input  logic                              clk,
    input  logic                              rstN,
    input  logic                              axiARValid,
    output logic                              axiARReady,
    input  logic [AxiIdWidth-1:0]             axiARId,
    input  logic [63:0]                       axiARAddr,
    input  logic [7:0]                        axiARLen,
    input  logic [2:0]                        axiARSize,
    output logic                              axiRValid,
    input  logic                              axiRReady,
    output logic [AxiIdWidth-1:0]             axiRId,
    output logic [(8<<DataIndexSize)-1:0]     axiRData,
    output logic [1:0]                        axiRResp,
    output logic                              axiRLast,
    output logic                              smiReqReady,
    input  logic                              smiReqStop,
    output logic [7:0]                        smiReqEofc,
    output logic [(8<<DataIndexSize)-1:0]     smiReqData,
    input  logic                              smiRespReady,
    output logic                              smiRespStop,
    input  logic [7:0]                        smiRespEofc,
    input  logic [(8<<DataIndexSize)-1:0]     smiRespData
);

    localparam int unsigned FlitWidth = 1 << DataIndexSize;
    localparam int unsigned DataWidth = FlitWidth * 8;
    localparam logic [7:0]  ReqEofc   = 8'd12;
    localparam logic [7:0]  ReadOp    = 8'h02;
    localparam logic [1:0]  RespOkay  = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HDR,
        S_DATA,
        S_PAD,
        S_DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic                   ar_ready_q, ar_ready_d;
    logic [AxiIdWidth-1:0]  id_q, id_d;
    logic [63:0]            addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             count_q, count_d;
    logic                   err_q, err_d;

    logic [DataWidth-1:0]   req_frame;
    logic                   last_beat;
    logic                   resp_done;
    logic [7:0]             hdr_tag;
    logic [7:0]             hdr_status;

    assign axiARReady = ar_ready_q;
    assign axiRId     = id_q;
    assign last_beat  = (count_q == len_q);
    assign resp_done  = (smiRespEofc != 8'd0);
    assign hdr_tag    = smiRespData[15:8];
    assign hdr_status = smiRespData[23:16];

    // Request flit: opcode, tag, byte count and address, all little-endian.
    always_comb begin
        req_frame        = '0;
        req_frame[7:0]   = ReadOp;
        req_frame[15:8]  = 8'(id_q);
        req_frame[31:16] = (16'(len_q) + 16'd1) << DataIndexSize;
        req_frame[95:32] = addr_q;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= S_IDLE;
            ar_ready_q <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ar_ready_q <= ar_ready_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        count_d     = count_q;
        err_d       = err_q;
        axiRValid   = 1'b0;
        axiRData    = '0;
        axiRResp    = RespOkay;
        axiRLast    = 1'b0;
        smiReqReady = 1'b0;
        smiReqEofc  = 8'd0;
        smiReqData  = '0;
        smiRespStop = 1'b1;

        case (state_q)
            S_IDLE: begin
                // Stray response flits are swallowed while no transaction is open.
                smiRespStop = 1'b0;
                if (axiARValid && ar_ready_q) begin
                    id_d    = axiARId;
                    addr_d  = axiARAddr;
                    len_d   = axiARLen;
                    count_d = 8'd0;
                    err_d   = 1'b0;
                    state_d = (axiARSize == 3'(DataIndexSize)) ? S_REQ : S_PAD;
                end
            end
            S_REQ: begin
                smiReqReady = 1'b1;
                smiReqEofc  = ReqEofc;
                smiReqData  = req_frame;
                if (!smiReqStop) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                smiRespStop = 1'b0;
                if (smiRespReady) begin
                    err_d   = (hdr_status != 8'd0) || (hdr_tag != 8'(id_q));
                    state_d = S_DATA;
                    if (resp_done) begin
                        err_d   = 1'b1;
                        state_d = S_PAD;
                    end
                end
            end
            S_DATA: begin
                // Flits flow straight through; SMI stop is AXI backpressure.
                axiRValid   = smiRespReady;
                smiRespStop = ~axiRReady;
                axiRData    = smiRespData;
                axiRResp    = err_q ? RespSlvErr : RespOkay;
                axiRLast    = last_beat;
                if (smiRespReady && axiRReady) begin
                    if (last_beat) begin
                        state_d = resp_done ? S_IDLE : S_DRAIN;
                    end else begin
                        count_d = count_q + 8'd1;
                        if (resp_done) begin
                            err_d   = 1'b1;
                            state_d = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                axiRValid = 1'b1;
                axiRResp  = RespSlvErr;
                axiRLast  = last_beat;
                if (axiRReady) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                smiRespStop = 1'b0;
                if (smiRespReady && resp_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ar_ready_d = (state_d == S_IDLE);
    end

endmodule

// File: tb/tb_axi_smi_read_bridge.sv
// Self-checking bench for axi_smi_read_bridge: scenario tasks plus randomized
// transactions compared against a transaction-level reference model.
module tb_axi_smi_read_bridge;

    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
        logic [3:0]   id;
    } beat_t;

    typedef struct packed {
        logic [127:0] data;
        logic [7:0]   eofc;
    } flit_t;

    logic         clk;
    logic         rstN;
    logic         axiARValid, axiARReady;
    logic [3:0]   axiARId;
    logic [63:0]  axiARAddr;
    logic [7:0]   axiARLen;
    logic [2:0]   axiARSize;
    logic         axiRValid, axiRReady;
    logic [3:0]   axiRId;
    logic [127:0] axiRData;
    logic [1:0]   axiRResp;
    logic         axiRLast;
    logic         smiReqReady, smiReqStop;
    logic [7:0]   smiReqEofc;
    logic [127:0] smiReqData;
    logic         smiRespReady, smiRespStop;
    logic [7:0]   smiRespEofc;
    logic [127:0] smiRespData;

    axi_smi_read_bridge #(.DataIndexSize(4), .AxiIdWidth(4)) dut (
        .clk(clk), .rstN(rstN),
        .axiARValid(axiARValid), .axiARReady(axiARReady), .axiARId(axiARId),
        .axiARAddr(axiARAddr), .axiARLen(axiARLen), .axiARSize(axiARSize),
        .axiRValid(axiRValid), .axiRReady(axiRReady), .axiRId(axiRId),
        .axiRData(axiRData), .axiRResp(axiRResp), .axiRLast(axiRLast),
        .smiReqReady(smiReqReady), .smiReqStop(smiReqStop), .smiReqEofc(smiReqEofc),
        .smiReqData(smiReqData), .smiRespReady(smiRespReady), .smiRespStop(smiRespStop),
        .smiRespEofc(smiRespEofc), .smiRespData(smiRespData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction description shared by the driver and the model.
    logic [3:0]   t_id;
    logic [63:0]  t_addr;
    logic [7:0]   t_len;
    logic [2:0]   t_size;
    logic [7:0]   t_tag, t_status, t_last_eofc;
    bit           t_hdr_nodata;
    int           t_ndata;
    logic [127:0] gen_data [0:299];

    beat_t        exp_q[$];
    beat_t        got_q[$];
    int           exp_req_cnt, req_cnt;
    logic [127:0] exp_req, req_data;
    logic [7:0]   req_eofc;
    bit           timed_out;
    int           mirror_err, stab_err, ar_cyc, rdy_cyc;

    function automatic logic [136:0] all_outputs();
        return {axiARReady, axiRValid, axiRId, axiRResp, axiRLast, smiReqReady,
                smiRespStop, smiReqEofc, 118'(axiRData ^ smiReqData)} |
               {9'd0, axiRData};
    endfunction

    task automatic set_idle();
        axiARValid   = 1'b0;
        smiReqStop   = 1'b0;
        smiRespReady = 1'b0;
        smiRespData  = '0;
        smiRespEofc  = 8'd0;
        axiRReady    = 1'b0;
    endtask

    // Reference model: what the AXI side and the SMI request must look like.
    function automatic void build_expected();
        bit    bad;
        bit    err;
        int    avail;
        int    nbytes;
        beat_t b;
        bad   = (t_size != 3'd4);
        err   = (t_status != 8'd0) || (t_tag != {4'd0, t_id}) || t_hdr_nodata;
        avail = t_hdr_nodata ? 0 : t_ndata;
        for (int i = 0; i < 300; i++) gen_data[i] = {$urandom, $urandom, $urandom, $urandom};
        exp_q.delete();
        for (int i = 0; i <= int'(t_len); i++) begin
            b.id   = t_id;
            b.last = (i == int'(t_len));
            if (!bad && i < avail) begin
                b.data = gen_data[i];
                b.resp = err ? 2'b10 : 2'b00;
            end else begin
                b.data = '0;
                b.resp = 2'b10;
            end
            exp_q.push_back(b);
        end
        exp_req_cnt     = bad ? 0 : 1;
        nbytes          = (int'(t_len) + 1) * 16;
        exp_req         = '0;
        exp_req[7:0]    = 8'h02;
        exp_req[15:8]   = {4'd0, t_id};
        exp_req[23:16]  = 8'(nbytes % 256);
        exp_req[31:24]  = 8'(nbytes / 256);
        for (int k = 0; k < 8; k++) exp_req[32 + 8*k +: 8] = 8'(t_addr >> (8*k));
    endfunction

    // Cycle-based driver: AR master, SMI responder and R consumer in one loop.
    task automatic drive_txn(input int rmode, input bit stall, input int abort_after);
        flit_t fq[$];
        flit_t f;
        beat_t cur, prev;
        bit    ar_done, req_seen, hold, got_last, pend, fin;
        ar_done = 0; req_seen = 0; hold = 0; got_last = 0; pend = 0; fin = 0;
        prev = '0;
        got_q.delete();
        req_cnt = 0; mirror_err = 0; stab_err = 0; ar_cyc = -1; rdy_cyc = -1;
        if (t_size == 3'd4) begin
            f.data = {104'd0, t_status, t_tag, 8'h02};
            f.eofc = t_hdr_nodata ? 8'd3 : 8'd0;
            fq.push_back(f);
            for (int i = 0; i < t_ndata; i++) begin
                f.data = gen_data[i];
                f.eofc = (i == t_ndata - 1) ? t_last_eofc : 8'd0;
                fq.push_back(f);
            end
        end
        axiARId = t_id; axiARAddr = t_addr; axiARLen = t_len; axiARSize = t_size;
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            axiARValid = !ar_done;
            smiReqStop = stall ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (!hold) begin
                if (req_seen && fq.size() > 0 && (!stall || $urandom_range(0, 3) != 0)) begin
                    smiRespReady = 1'b1;
                    smiRespData  = fq[0].data;
                    smiRespEofc  = fq[0].eofc;
                end else begin
                    smiRespReady = 1'b0;
                    smiRespData  = '0;
                    smiRespEofc  = 8'd0;
                end
            end
            axiRReady = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
            #1;
            if (axiARValid && axiARReady) begin ar_done = 1; ar_cyc = c; end
            if (smiReqReady && !smiReqStop) begin
                req_cnt++; req_data = smiReqData; req_eofc = smiReqEofc; req_seen = 1;
            end
            if (smiRespReady && !smiRespStop) begin
                void'(fq.pop_front());
                hold = 0;
            end else begin
                hold = smiRespReady;
            end
            if (smiRespReady && axiRValid && (smiRespStop !== !axiRReady)) mirror_err++;
            cur = '{axiRData, axiRResp, axiRLast, axiRId};
            if (pend && (!axiRValid || cur !== prev)) stab_err++;
            pend = axiRValid && !axiRReady;
            prev = cur;
            if (axiRValid && axiRReady) begin
                got_q.push_back(cur);
                if (axiRLast) got_last = 1;
            end
            if (abort_after > 0 && got_q.size() >= abort_after) begin fin = 1; break; end
            if (ar_done && got_last && rdy_cyc < 0 && axiARReady) rdy_cyc = c;
            if (rdy_cyc >= 0 && fq.size() == 0) begin fin = 1; break; end
            @(negedge clk);
        end
        timed_out = !fin;
        set_idle();
    endtask

    task automatic set_txn(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [7:0] tag, input logic [7:0] status,
                           input bit nodata, input int ndata, input logic [7:0] leofc);
        t_id = id; t_addr = addr; t_len = len; t_size = size; t_tag = tag;
        t_status = status; t_hdr_nodata = nodata; t_ndata = ndata; t_last_eofc = leofc;
        build_expected();
    endtask

    task automatic test_reset();
        set_idle();
        rstN = 1'b1;
        #2 rstN = 1'b0;
        #1;
        n_tests++;
        if (all_outputs() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h, expected 0", all_outputs());
        end
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        #1;
        n_tests++;
        if (axiARReady !== 1'b0) begin
            n_fail++; $display("FAIL reset_arready_before_edge: got %b, expected 0", axiARReady);
        end
        @(posedge clk); #1;
        n_tests++;
        if (axiARReady !== 1'b1) begin
            n_fail++; $display("FAIL reset_arready_after_edge: got %b, expected 1", axiARReady);
        end
    endtask

    task automatic test_single_beat();
        set_txn(4'd3, 64'h1000, 8'd0, 3'd4, 8'd3, 8'd0, 0, 1, 8'd16);
        drive_txn(0, 0, 0);
        n_tests++;
        if (timed_out || req_cnt != exp_req_cnt) begin
            n_fail++; $display("FAIL single_req_count: got %0d timeout=%0b, expected %0d", req_cnt, timed_out, exp_req_cnt);
        end
        n_tests++;
        if ({req_eofc, req_data} !== {8'd12, exp_req}) begin
            n_fail++; $display("FAIL single_req_flit: got eofc=%0d %h, expected eofc=12 %h", req_eofc, req_data, exp_req);
        end
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL single_beats: got %0d, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL single_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_burst_backpressure();
        set_txn(4'd9, 64'h0000_0040_0000_2000, 8'd3, 3'd4, 8'd9, 8'd0, 0, 4, 8'd16);
        drive_txn(1, 0, 0);
        n_tests++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_beats: got %0d timeout=%0b, expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (mirror_err != 0 || stab_err != 0) begin
            n_fail++; $display("FAIL bp_stop_mirror: got mirror_err=%0d stab_err=%0d, expected 0/0", mirror_err, stab_err);
        end
    endtask

    task automatic test_error_status();
        set_txn(4'd5, 64'h0000_0000_0000_3000, 8'd1, 3'd4, 8'd5, 8'h05, 0, 2, 8'd8);
        drive_txn(0, 1, 0);
        n_tests++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL errst_beats: got %0d timeout=%0b, expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL errst_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        set_txn(4'd2, 64'h0000_0000_0000_4000, 8'd3, 3'd4, 8'd2, 8'd0, 0, 1, 8'd16);
        drive_txn(0, 0, 0);
        n_tests++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL short_beats: got %0d timeout=%0b, expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL short_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_bad_size_overlong();
        set_txn(4'd7, 64'h0000_0000_0000_5000, 8'd4, 3'd2, 8'd7, 8'd0, 0, 0, 8'd16);
        drive_txn(2, 0, 0);
        n_tests++;
        if (timed_out || req_cnt != exp_req_cnt || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL badsize: got req=%0d beats=%0d timeout=%0b, expected req=%0d beats=%0d",
                               req_cnt, got_q.size(), timed_out, exp_req_cnt, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL badsize_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        set_txn(4'd1, 64'h0000_0000_0000_6000, 8'd0, 3'd4, 8'd1, 8'd0, 0, 3, 8'd4);
        drive_txn(0, 0, 0);
        n_tests++;
        if (timed_out || got_q.size() != exp_q.size() || axiARReady !== 1'b1) begin
            n_fail++; $display("FAIL overlong: got beats=%0d arready=%b timeout=%0b, expected beats=%0d arready=1",
                               got_q.size(), axiARReady, timed_out, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL overlong_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            set_txn(4'(k + 10), {$urandom, $urandom}, 8'd0, 3'd4, 8'(k + 10), 8'd0, 0, 1, 8'd16);
            drive_txn(0, 0, 0);
            n_tests++;
            if (timed_out || rdy_cyc - ar_cyc != 4) begin
                n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles timeout=%0b, expected 4", k, rdy_cyc - ar_cyc, timed_out);
            end
            n_tests++;
            if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
                n_fail++; $display("FAIL b2b_beat%0d: got %0d beats first %h, expected 1 beat %h",
                                   k, got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        set_txn(4'd6, 64'h0000_0000_0000_7000, 8'd7, 3'd4, 8'd6, 8'd0, 0, 8, 8'd16);
        drive_txn(0, 0, 2);
        rstN = 1'b0;
        #1;
        n_tests++;
        if (all_outputs() !== '0) begin
            n_fail++; $display("FAIL arst_outputs: got %h, expected 0", all_outputs());
        end
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (axiARReady !== 1'b1) begin
            n_fail++; $display("FAIL arst_arready: got %b, expected 1", axiARReady);
        end
        set_txn(4'd4, 64'h0000_0000_0000_8000, 8'd2, 3'd4, 8'd4, 8'd0, 0, 3, 8'd16);
        drive_txn(2, 1, 0);
        n_tests++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL arst_newtxn: got %0d beats timeout=%0b, expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL arst_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] id;
        logic [7:0] len;
        bit         nodata;
        for (int n = 0; n < 15; n++) begin
            id     = 4'($urandom_range(0, 15));
            len    = (n == 0) ? 8'd255 : ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
            nodata = ($urandom_range(0, 9) == 0);
            set_txn(id, {$urandom, $urandom}, len,
                    ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd4,
                    ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : {4'd0, id},
                    ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                    nodata, nodata ? 0 : int'($urandom_range(1, int'(len) + 3)),
                    8'($urandom_range(1, 16)));
            drive_txn(2, 1, 0);
            n_tests++;
            if (timed_out || req_cnt != exp_req_cnt || got_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_counts: got req=%0d beats=%0d timeout=%0b, expected req=%0d beats=%0d",
                                   n, req_cnt, got_q.size(), timed_out, exp_req_cnt, exp_q.size());
            end
            n_tests++;
            if (exp_req_cnt == 1 && {req_eofc, req_data} !== {8'd12, exp_req}) begin
                n_fail++; $display("FAIL rand%0d_req: got eofc=%0d %h, expected eofc=12 %h", n, req_eofc, req_data, exp_req);
            end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand%0d_beat%0d: got %h, expected %h", n, i, got_q[i], exp_q[i]);
                end
            end
            n_tests++;
            if (mirror_err != 0 || stab_err != 0) begin
                n_fail++; $display("FAIL rand%0d_handshake: got mirror_err=%0d stab_err=%0d, expected 0/0", n, mirror_err, stab_err);
            end
        end
    endtask

    initial begin
        axiARId = '0; axiARAddr = '0; axiARLen = '0; axiARSize = '0;
        test_reset();
        test_single_beat();
        test_burst_backpressure();
        test_error_status();
        test_short_frame();
        test_bad_size_overlong();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
